systolic_seq_ctrl: RTL

- Sequencer for the 8-lane systolic shift array.
- Accepts a command giving a vector count, then streams that many input vectors into the array.
- Advances the array only via an enable strobe, and tracks in-flight vectors with a DEPTH-bit tag pipeline.
- Captures each vector emerging at the array tail into a valid/ready output register, then flushes and pulses done; sits between the host I/O byte interface and the array.

---
 rtl/systolic_pkg.sv | 17 +
 rtl/systolic_tag_pipe.sv | 24 ++
 rtl/systolic_seq_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared types and default sizing for the systolic array sequencer.
`timescale 1ns/1ps
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 16;
  localparam int LEN_W_DEF = 4;
  localparam int PERF_W    = 16;

endpackage

// File: rtl/systolic_tag_pipe.sv
// Enable-gated shift register that marks which array slots hold real vectors.
`timescale 1ns/1ps
module systolic_tag_pipe #(
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_bit,
  output logic [DEPTH-1:0] tags,
  output logic             tail
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tags <= '0;
    end else if (en) begin
      tags <= {tags[DEPTH-2:0], in_bit};
    end
  end

  assign tail = tags[DEPTH-1];

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer streaming command-sized bursts through the systolic shift array.
// Optional stall counter enabled by defining SYSTOLIC_SEQ_PERF_EN.
`timescale 1ns/1ps
module systolic_seq_ctrl
  import systolic_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              arr_en,
  output logic [WIDTH-1:0]  arr_in,
  input  logic [WIDTH-1:0]  arr_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              busy,
  output logic              done,
  output logic [PERF_W-1:0] perf_stall
);

  state_t             state;
  state_t             state_nxt;
  logic [LEN_W-1:0]   remaining;
  logic [DEPTH-1:0]   tags;
  logic               tail;
  logic               adv_ok;
  logic               cmd_acc;
  logic               in_acc;
  logic               tag_in;

  systolic_tag_pipe #(.DEPTH(DEPTH)) u_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .en     (arr_en),
    .in_bit (tag_in),
    .tags   (tags),
    .tail   (tail)
  );

  // A real tail vector may only advance if the output slot is free or draining.
  assign adv_ok = !tail || !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    arr_en    = 1'b0;
    arr_in    = '0;
    tag_in    = 1'b0;
    done      = 1'b0;
    cmd_acc   = 1'b0;
    in_acc    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cmd_acc   = 1'b1;
          state_nxt = (cmd_len == '0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        in_ready = adv_ok;
        if (in_valid && adv_ok) begin
          in_acc = 1'b1;
          arr_en = 1'b1;
          arr_in = in_data;
          tag_in = 1'b1;
          if (remaining == LEN_W'(1)) begin
            state_nxt = FLUSH;
          end
        end
      end
      FLUSH: begin
        arr_en = adv_ok && (|tags);
        if ((tags == '0) && !out_valid) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= '0;
    end else if (cmd_acc) begin
      remaining <= cmd_len;
    end else if (in_acc) begin
      remaining <= remaining - LEN_W'(1);
    end
  end

  // Capture wins over pop so a simultaneous accept-and-refill keeps the slot full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (arr_en && tail) begin
      out_valid <= 1'b1;
      out_data  <= arr_out;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

`ifdef SYSTOLIC_SEQ_PERF_EN
  logic [PERF_W-1:0] stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (cmd_acc) begin
      stall_cnt <= '0;
    end else if (((state == STREAM) || (state == FLUSH)) && !arr_en && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + PERF_W'(1);
    end
  end

  assign perf_stall = stall_cnt;
`else
  assign perf_stall = '0;
`endif

endmodule
